// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the core decoder and instr_encoder: opcodes, funct fields,
// the NOP word, the req_op encoding and the encoder state enum.
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one symbolic request (op, rd, rs1, rs2, imm) to an RV32I word.
// Fields an op does not use pass through unmasked into their slots or are simply dropped.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word
);

  // imm[0] is never encoded: branch offsets are always even.
  logic unused_imm0;
  assign unused_imm0 = imm[0];

  always_comb begin
    word = NOP_WORD;
    case (op)
      OP_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_RTYPE};
      OP_SUB: word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_RTYPE};
      OP_AND: word = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_RTYPE};
      OP_OR:  word = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_RTYPE};
      OP_LW:  word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
      OP_SW:  word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      OP_BEQ: word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
      default: word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder / program loader writing packed words to consecutive addresses.
// Optional macro IMM_CHECK_EN enables the sticky immediate-range error flag on err.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  enc_state_e        state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              hs;
  logic              at_cap;
  logic              start_ok;

  instr_pack u_pack (
    .op   (req_op),
    .rd   (req_rd),
    .rs1  (req_rs1),
    .rs2  (req_rs2),
    .imm  (req_imm),
    .word (word)
  );

  assign req_ready = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign hs        = req_valid && req_ready;
  assign start_ok  = start && (state != ST_LOAD);
  // This handshake delivers the last word that fits in memory.
  assign at_cap    = (count == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD:          if (hs && (req_last || at_cap)) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= BASE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'h0;
      count     <= '0;
      full      <= 1'b0;
    end else begin
      mem_we <= hs;
      if (start_ok) begin
        ptr   <= BASE;
        count <= '0;
        full  <= 1'b0;
      end
      if (hs) begin
        mem_addr  <= ptr;
        mem_wdata <= word;
        ptr       <= ptr + 1'b1;
        count     <= count + 1'b1;
        if (at_cap && !req_last) full <= 1'b1;
      end
    end
  end

`ifdef IMM_CHECK_EN
  logic err_q;
  logic imm_bad;

  // LW/SW need imm to fit 12 signed bits; BEQ offsets must be even.
  assign imm_bad = (((req_op == OP_LW) || (req_op == OP_SW)) && (req_imm[12] != req_imm[11]))
                || ((req_op == OP_BEQ) && req_imm[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             err_q <= 1'b0;
    else if (start_ok)      err_q <= 1'b0;
    else if (hs && imm_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan sequences with literal checks,
// then randomized traffic compared every cycle against a behavioural loader model.
module tb_instr_encoder;

  localparam int AW   = 4;
  localparam int CAP  = 1 << AW;
  localparam int BASE = 10;
`ifdef IMM_CHECK_EN
  localparam logic IMM_EN = 1'b1;
`else
  localparam logic IMM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_last = 1'b0;
  logic [2:0]    req_op = 3'd0;
  logic [4:0]    req_rd = 5'd0;
  logic [4:0]    req_rs1 = 5'd0;
  logic [4:0]    req_rs2 = 5'd0;
  logic [12:0]   req_imm = 13'd0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          busy, done, full, err;

  int n_cmp = 0;
  int n_fail = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_last  (req_last),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference encoding built from field values with shifts, straight from the ISA tables.
  function automatic logic [31:0] refEncode(input logic [31:0] op, input logic [31:0] rd,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm);
    logic [31:0] u;
    u = imm & 32'h1fff;
    case (op)
      0: return (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      1: return (32'h20 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      2: return (rs2 << 20) | (rs1 << 15) | (32'd7 << 12) | (rd << 7) | 32'h33;
      3: return (rs2 << 20) | (rs1 << 15) | (32'd6 << 12) | (rd << 7) | 32'h33;
      4: return ((u & 32'hfff) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
      5: return (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
              | ((u & 32'h1f) << 7) | 32'h23;
      6: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20)
              | (rs1 << 15) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
      default: return 32'h13;
    endcase
  endfunction

  function automatic logic refImmBad(input logic [31:0] op, input logic [31:0] imm);
    if (op == 4 || op == 5) return ((imm >> 12) & 1) != ((imm >> 11) & 1);
    if (op == 6)            return (imm & 1) != 0;
    return 1'b0;
  endfunction

  // Behavioural model of the loader session.
  logic        m_load = 1'b0, m_done = 1'b0, m_full = 1'b0, m_err = 1'b0, m_we = 1'b0;
  int          m_ptr = BASE, m_count = 0, m_addr = BASE;
  logic [31:0] m_wdata = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load = 0; m_done = 0; m_full = 0; m_err = 0; m_we = 0;
      m_ptr = BASE; m_count = 0; m_addr = BASE; m_wdata = 0;
    end else begin
      m_we = 0;
      if (m_load) begin
        if (req_valid) begin
          m_we    = 1;
          m_addr  = m_ptr;
          m_wdata = refEncode(32'(req_op), 32'(req_rd), 32'(req_rs1), 32'(req_rs2), 32'(req_imm));
          m_ptr   = (m_ptr + 1) % CAP;
          m_count = m_count + 1;
          if (IMM_EN && refImmBad(32'(req_op), 32'(req_imm))) m_err = 1;
          if (req_last || m_count == CAP) begin
            m_load = 0;
            m_done = 1;
            m_full = !req_last;
          end
        end
      end else if (start) begin
        m_load = 1; m_done = 0; m_full = 0; m_err = 0;
        m_ptr = BASE; m_count = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("cyc_ready", 32'(req_ready), 32'(m_load));
    checkOutput("cyc_busy",  32'(busy),      32'(m_load));
    checkOutput("cyc_done",  32'(done),      32'(m_done));
    checkOutput("cyc_full",  32'(full),      32'(m_full));
    checkOutput("cyc_err",   32'(err),       32'(m_err));
    checkOutput("cyc_count", 32'(count),     32'(m_count));
    checkOutput("cyc_we",    32'(mem_we),    32'(m_we));
    checkOutput("cyc_addr",  32'(mem_addr),  32'(m_addr));
    checkOutput("cyc_wdata", mem_wdata,      m_wdata);
  end

  task automatic applyStimulus(input logic v, input logic l, input logic [2:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [12:0] imm);
    req_valid = v; req_last = l; req_op = op;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    @(posedge clk); #1;
    req_valid = 1'b0; req_last = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic randomReq(input logic l);
    applyStimulus(1'b1, l, 3'($urandom_range(7)), 5'($urandom), 5'($urandom),
                  5'($urandom), 13'($urandom));
  endtask

  initial begin
    #13;
    checkOutput("rst_we",    32'(mem_we),    32'd0);
    checkOutput("rst_addr",  32'(mem_addr),  BASE);
    checkOutput("rst_wdata", mem_wdata,      32'd0);
    checkOutput("rst_count", 32'(count),     32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_flags", {28'd0, busy, done, full, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD then SUB with last
    pulseStart();
    checkOutput("start_ready", 32'(req_ready), 32'd1);
    applyStimulus(1, 0, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    checkOutput("add_we",    32'(mem_we),   32'd1);
    checkOutput("add_addr",  32'(mem_addr), BASE);
    checkOutput("add_word",  mem_wdata,     32'h002081B3);
    applyStimulus(1, 1, 3'd1, 5'd5, 5'd6, 5'd7, 13'd0);
    checkOutput("sub_addr",  32'(mem_addr), BASE + 1);
    checkOutput("sub_word",  mem_wdata,     32'h407302B3);
    checkOutput("sub_done",  32'(done),     32'd1);
    checkOutput("sub_busy",  32'(busy),     32'd0);
    checkOutput("sub_count", 32'(count),    32'd2);
    applyStimulus(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    checkOutput("done_hold", 32'(done),     32'd1);
    checkOutput("idle_we",   32'(mem_we),   32'd0);

    // LW, SW, BEQ, NOP
    pulseStart();
    applyStimulus(1, 0, 3'd4, 5'd5, 5'd2, 5'd0, 13'd8);
    checkOutput("lw_word", mem_wdata, 32'h00812283);
    applyStimulus(1, 0, 3'd5, 5'd0, 5'd2, 5'd5, 13'd12);
    checkOutput("sw_word", mem_wdata, 32'h00512623);
    applyStimulus(1, 0, 3'd6, 5'd0, 5'd1, 5'd2, 13'h1FFC);
    checkOutput("beq_word", mem_wdata, 32'hFE208EE3);
    applyStimulus(1, 1, 3'd7, 5'd9, 5'd9, 5'd9, 13'h0AAA);
    checkOutput("nop_word", mem_wdata, 32'h00000013);
    checkOutput("nop_addr", 32'(mem_addr), BASE + 3);

    // Fill to capacity without last, address wraps modulo CAP
    pulseStart();
    for (int i = 0; i < CAP; i++) begin
      randomReq(1'b0);
      checkOutput("cap_addr", 32'(mem_addr), 32'((BASE + i) % CAP));
    end
    checkOutput("cap_done",  32'(done),  32'd1);
    checkOutput("cap_full",  32'(full),  32'd1);
    checkOutput("cap_count", 32'(count), CAP);
    checkOutput("cap_ready", 32'(req_ready), 32'd0);
    randomReq(1'b0);
    checkOutput("cap_extra_we",    32'(mem_we), 32'd0);
    checkOutput("cap_extra_count", 32'(count),  CAP);

    // valid 1,0,1 with a stray start in the gap
    pulseStart();
    checkOutput("restart_full", 32'(full), 32'd0);
    applyStimulus(1, 0, 3'd2, 5'd1, 5'd2, 5'd3, 13'd0);
    checkOutput("tog_we0", 32'(mem_we), 32'd1);
    start = 1'b1;
    applyStimulus(0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    start = 1'b0;
    checkOutput("tog_we1",    32'(mem_we), 32'd0);
    checkOutput("tog_count1", 32'(count),  32'd1);
    applyStimulus(1, 1, 3'd3, 5'd4, 5'd5, 5'd6, 13'd0);
    checkOutput("tog_we2",   32'(mem_we),   32'd1);
    checkOutput("tog_addr2", 32'(mem_addr), BASE + 1);
    checkOutput("tog_count", 32'(count),    32'd2);

    // Out-of-range LW immediate
    pulseStart();
    applyStimulus(1, 0, 3'd4, 5'd1, 5'd0, 5'd0, 13'd2048);
    checkOutput("imm_word", mem_wdata,   32'h80002083);
    checkOutput("imm_err",  32'(err),    32'(IMM_EN));
    applyStimulus(1, 1, 3'd7, 5'd0, 5'd0, 5'd0, 13'd0);
    checkOutput("imm_err_sticky", 32'(err), 32'(IMM_EN));
    pulseStart();
    checkOutput("imm_err_clr", 32'(err), 32'd0);

    // Reset in the middle of a session
    req_valid = 1'b1; req_last = 1'b0; req_op = 3'd0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we",    32'(mem_we),    32'd0);
    checkOutput("midrst_busy",  32'(busy),      32'd0);
    checkOutput("midrst_count", 32'(count),     32'd0);
    checkOutput("midrst_addr",  32'(mem_addr),  BASE);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulseStart();
    applyStimulus(1, 0, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    checkOutput("resume_addr",  32'(mem_addr), BASE);
    checkOutput("resume_count", 32'(count),    32'd1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      start     = ($urandom_range(15) == 0);
      req_valid = ($urandom_range(3) != 0);
      req_last  = ($urandom_range(11) == 0);
      req_op    = 3'($urandom_range(7));
      req_rd    = 5'($urandom);
      req_rs1   = 5'($urandom);
      req_rs2   = 5'($urandom);
      req_imm   = 13'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader: the inverse of the core's instruction decoder. It accepts a stream of symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake. It packs each request into a 32-bit RV32I word and writes it into instruction memory at consecutive word addresses. It sits between the test/boot sequencer and the instruction-memory write port, and supports exactly the subset the core decodes: add, sub, and, or, lw, sw, beq, plus nop.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- BASE_ADDR, 0, first word address written after start
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a load session
- req_valid  in  1  request valid
- req_ready  out  1  encoder can accept a request this cycle
- req_last  in  1  request is the final one of the session
- req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 LW, 5 SW, 6 BEQ, 7 NOP
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  13  signed immediate; LW/SW use [11:0], BEQ uses [12:1]
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- busy  out  1  state is LOAD
- done  out  1  state is DONE
- full  out  1  session ended on capacity, not req_last
- err  out  1  sticky immediate error (see Configuration)

## Operation
- States are IDLE, LOAD and DONE. Reset and power-up enter IDLE.
- IDLE or DONE with start=1 goes to LOAD. The address pointer loads BASE_ADDR, and count, full and err clear.
- start is ignored while in LOAD.
- req_ready = (state==LOAD). A handshake is req_valid && req_ready. Memory never back-pressures.
- On a handshake, the registered outputs update next cycle:
  - mem_we=1, mem_addr=pointer, mem_wdata=encoded word.
  - pointer increments modulo 2^ADDR_W, and count increments.
- Without a handshake, mem_we=0 and mem_addr/mem_wdata hold.
- LOAD goes to DONE when the handshaked request has req_last=1, or when it is the 2^ADDR_W-th word of the session (count reaching 2^ADDR_W). In the capacity case without req_last, full=1.
- Encoding, standard RV32I field placement:
  - ADD, SUB, AND, OR: opcode 0110011. funct3 is 000, 000, 111, 110. funct7 is 0100000 for SUB, 0000000 otherwise.
  - LW: opcode 0000011, funct3 010, imm[11:0] in bits 31:20.
  - SW: opcode 0100011, funct3 010, imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
  - BEQ: opcode 1100011, funct3 000, imm[12|10:5] in bits 31:25, imm[4:1|11] in bits 11:7.
  - NOP: 0x00000013. Register and immediate inputs are ignored.
- Unused fields are not masked: R-type ignores req_imm, LW ignores req_rs2, SW/BEQ ignore req_rd.

## Timing
- Reset values: state IDLE, req_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, busy 0, done 0, full 0, err 0.
- Latency: handshake in cycle N gives the memory write in cycle N+1. Throughput is one word per cycle.
- Final handshake in cycle N:
  - cycle N+1: state DONE; done=1, busy=0, req_ready=0, and the last word's mem_we=1 in the same cycle.
  - done holds until the next start.
- start pulse in cycle N: req_ready=1 from cycle N+1.
- An rst_n assertion mid-session forces all outputs to reset values immediately. The in-flight word is not written.

## Configuration
- IMM_CHECK_EN defined:
  - err sets, sticky until start, when a handshaked LW/SW has req_imm[12]!=req_imm[11] (out of 12-bit signed range), or a BEQ has req_imm[0]=1.
  - The word is still written, with truncated/ignored bits.
- IMM_CHECK_EN undefined: the err port exists and is tied 0. No check logic.

## Structure
- The shared package riscv_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OPIMM)
  - funct3/funct7 constants and the NOP word
  - the req_op encoding
  - the encoder state enum
- These are the same opcode constants the decoder consumes.
- Sub-module instr_pack: purely combinational (op, rd, rs1, rs2, imm) to 32-bit word. instr_encoder adds the FSM, pointer, counter, output registers and the check.

## Test plan
- Reset, start, then ADD rd=3 rs1=1 rs2=2, then SUB rd=5 rs1=6 rs2=7 with last:
  - mem_wdata 0x002081B3 at address 0, then 0x407302B3 at address 1.
  - done=1 in the second write cycle; count=2.
- LW rd=5 rs1=2 imm=8; SW rs2=5 rs1=2 imm=12; BEQ rs1=1 rs2=2 imm=-4; NOP with last:
  - words 0x00812283, 0x00512623, 0xFE208EE3, 0x00000013 on consecutive cycles.
- ADDR_W=2, four requests without last:
  - addresses 0,1,2,3; done=1, full=1 after the fourth.
  - A fifth req_valid is not accepted (req_ready=0).
- req_valid toggling 1,0,1:
  - mem_we pattern 1,0,1 one cycle later; addresses contiguous.
  - start asserted mid-LOAD has no effect on pointer or count.
- With IMM_CHECK_EN: LW imm=2048 sets err=1, and the word is still written. A following start clears err.
- rst_n low during LOAD: mem_we=0 and state IDLE immediately. The next start resumes at BASE_ADDR with count 0.
